// File: rtl/seq_detect_prog_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_detect_prog_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Width needed to hold a length value of 0..max_len inclusive.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Match counter with synchronous clear; saturates at all-ones when
// SEQ_DETECT_PROG_CNT_SAT_EN is defined, otherwise wraps.
module seq_match_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment only, so every
      // register samples the pre-edge values regardless of statement order.
      if (reset || clr) begin
         count <= '0;
      end else if (inc) begin
`ifdef SEQ_DETECT_PROG_CNT_SAT_EN
         if (count != '1) begin
            count <= count + CNT_W'(1);
         end
`else
         count <= count + CNT_W'(1);
`endif
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector (overlapping or non-overlapping).
// Optional build macro: SEQ_DETECT_PROG_CNT_SAT_EN (saturating match counter).
module seq_detect_prog
   import seq_detect_prog_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 16,
   localparam int LEN_W   = len_width(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               inp_bit,
   output logic               seq_seen,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err,
   output logic               armed
);

   typedef struct packed {
      logic [MAX_LEN-1:0] pattern;
      logic [LEN_W-1:0]   len;
      logic               overlap;
   } cfg_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t             state, state_nxt;
   cfg_t               cfg_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_inc;
   logic               len_ok;
   logic               load;
   logic               shift;
   logic               match;
   logic               hit;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      // NOTE: the default assignment before the case keeps this purely
      // combinational; without it a missed path would infer a latch.
      state_nxt = state;
      case (state)
         ST_IDLE: if (load) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      armed = (state == ST_RUN);
   end

   // ---------------- Datapath control ----------------
   assign len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
   assign load       = cfg_we && len_ok;
   // A cfg write in the same cycle always wins over the data bit.
   assign shift      = (state == ST_RUN) && !cfg_we && in_valid;
   assign hist_shift = {hist_q[MAX_LEN-2:0], inp_bit};
   assign fill_inc   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < cfg_q.len);
      end
   end

   assign match = (fill_inc >= cfg_q.len) &&
                  (((hist_shift ^ cfg_q.pattern) & len_mask) == '0);
   assign hit   = shift && match;

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q    <= '0;
         hist_q   <= '0;
         fill_q   <= '0;
         seq_seen <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         seq_seen <= hit;
         cfg_err  <= cfg_we && !len_ok;
         if (load) begin
            cfg_q  <= '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
            hist_q <= '0;
            fill_q <= '0;
         end else if (shift) begin
            if (match && !cfg_q.overlap) begin
               hist_q <= '0;
               fill_q <= '0;
            end else begin
               hist_q <= hist_shift;
               fill_q <= fill_inc;
            end
         end
      end
   end

   seq_match_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (load),
      .inc   (hit),
      .count (match_count)
   );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed cases plus randomized
// traffic against a queue-based reference model (also covers a 2-bit counter).
module tb_seq_detect_prog;

   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 16;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk;
   logic               reset;
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               in_valid;
   logic               inp_bit;

   logic               seq_seen,   seq_seen_n;
   logic [CNT_W-1:0]   match_count;
   logic [1:0]         match_count_n;
   logic               cfg_err,    cfg_err_n;
   logic               armed,      armed_n;

   int n_vec;
   int n_miss;

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .inp_bit     (inp_bit),
      .seq_seen    (seq_seen),
      .match_count (match_count),
      .cfg_err     (cfg_err),
      .armed       (armed)
   );

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_narrow (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .inp_bit     (inp_bit),
      .seq_seen    (seq_seen_n),
      .match_count (match_count_n),
      .cfg_err     (cfg_err_n),
      .armed       (armed_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- Reference model ----------------
   // History is a queue of received bits (oldest at front), capped at MAX_LEN.
   bit                 m_run;
   bit                 m_hist[$];
   int                 m_cnt;
   logic [MAX_LEN-1:0] m_pat;
   int                 m_len;
   bit                 m_ovl;
   bit                 e_seen;
   bit                 e_err;

   function automatic bit model_match();
      if (m_hist.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      e_seen = 1'b0;
      e_err  = 1'b0;
      if (reset) begin
         m_run = 1'b0;
         m_hist.delete();
         m_cnt = 0;
         m_pat = '0;
         m_len = 0;
         m_ovl = 1'b0;
      end else if (cfg_we) begin
         if (int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_LEN) begin
            m_pat = cfg_pattern;
            m_len = int'(cfg_len);
            m_ovl = cfg_overlap;
            m_hist.delete();
            m_cnt = 0;
            m_run = 1'b1;
         end else begin
            e_err = 1'b1;
         end
      end else if (m_run && in_valid) begin
         m_hist.push_back(inp_bit);
         if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
         if (model_match()) begin
            e_seen = 1'b1;
            m_cnt++;
            if (!m_ovl) m_hist.delete();
         end
      end
   endtask

   function automatic int narrow_expect(input int cnt);
`ifdef SEQ_DETECT_PROG_CNT_SAT_EN
      return (cnt > 3) ? 3 : cnt;
`else
      return cnt % 4;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, advance the model, then compare after the edge.
   task automatic step(input logic rst, input logic we, input logic [MAX_LEN-1:0] pat,
                       input logic [LEN_W-1:0] len, input logic ovl,
                       input logic iv, input logic b);
      reset       = rst;
      cfg_we      = we;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      in_valid    = iv;
      inp_bit     = b;
      model_step();
      @(posedge clk);
      #1;
      check("seq_seen",    {31'd0, seq_seen},   {31'd0, e_seen});
      check("match_count", {16'd0, match_count}, m_cnt % 65536);
      check("cfg_err",     {31'd0, cfg_err},    {31'd0, e_err});
      check("armed",       {31'd0, armed},      {31'd0, m_run});
      check("count_narrow", {30'd0, match_count_n}, narrow_expect(m_cnt));
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl);
      step(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0);
   endtask

   // Feeds n bits MSB-first (bits[n-1] is first); returns which steps pulsed.
   task automatic feed_bits(input logic [15:0] bits, input logic [15:0] valids,
                            input int n, output int mask);
      mask = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, '0, '0, 1'b0, valids[n-1-i], bits[n-1-i]);
         if (seq_seen === 1'b1) mask |= (1 << i);
      end
   endtask

   int mask;

   initial begin
      n_vec  = 0;
      n_miss = 0;
      m_cnt  = 0;
      m_run  = 1'b0;
      m_len  = 0;

      do_reset();
      check("reset_armed", {31'd0, armed}, 32'd0);
      check("reset_count", {16'd0, match_count}, 32'd0);

      // 1011, overlapping: pulses after bits 4 and 7.
      load_cfg(8'b0000_1011, 4'd4, 1'b1);
      check("cfg_armed", {31'd0, armed}, 32'd1);
      feed_bits(16'b1011011, 16'h7F, 7, mask);
      check("ovl1011_pulses", mask, 32'd72);
      check("ovl1011_count", {16'd0, match_count}, 32'd2);

      // 1011, non-overlapping: reload in RUN clears count.
      load_cfg(8'b0000_1011, 4'd4, 1'b0);
      check("reload_count", {16'd0, match_count}, 32'd0);
      feed_bits(16'b1011011, 16'h7F, 7, mask);
      check("novl1011_pulses", mask, 32'd8);
      check("novl1011_count", {16'd0, match_count}, 32'd1);

      // 101 overlapping / non-overlapping.
      load_cfg(8'b0000_0101, 4'd3, 1'b1);
      feed_bits(16'b10101, 16'h1F, 5, mask);
      check("ovl101_pulses", mask, 32'd20);
      check("ovl101_count", {16'd0, match_count}, 32'd2);
      load_cfg(8'b0000_0101, 4'd3, 1'b0);
      feed_bits(16'b10101, 16'h1F, 5, mask);
      check("novl101_pulses", mask, 32'd4);
      check("novl101_count", {16'd0, match_count}, 32'd1);

      // Illegal lengths in IDLE.
      do_reset();
      load_cfg(8'hFF, 4'd0, 1'b1);
      check("err_len0", {31'd0, cfg_err}, 32'd1);
      check("err_len0_armed", {31'd0, armed}, 32'd0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("err_one_cycle", {31'd0, cfg_err}, 32'd0);
      load_cfg(8'hFF, 4'(MAX_LEN + 1), 1'b1);
      check("err_len9", {31'd0, cfg_err}, 32'd1);
      feed_bits(16'hFFFF, 16'hFFFF, 10, mask);
      check("idle_no_pulse", mask, 32'd0);
      check("idle_armed", {31'd0, armed}, 32'd0);

      // Gaps in in_valid, then reset mid-pattern.
      load_cfg(8'b0000_1011, 4'd4, 1'b1);
      feed_bits(16'b1000101, 16'b1010101, 7, mask);
      check("gap_pulses", mask, 32'd64);
      feed_bits(16'b101, 16'h7, 3, mask);
      step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      check("midrst_armed", {31'd0, armed}, 32'd0);
      check("midrst_count", {16'd0, match_count}, 32'd0);
      feed_bits(16'b1, 16'b1, 1, mask);
      check("midrst_no_pulse", mask, 32'd0);

      // Narrow counter wrap / saturation: five matches.
      load_cfg(8'b0000_0001, 4'd1, 1'b1);
      feed_bits(16'h1F, 16'h1F, 5, mask);
      check("five_count", {16'd0, match_count}, 32'd5);
`ifdef SEQ_DETECT_PROG_CNT_SAT_EN
      check("narrow_sat", {30'd0, match_count_n}, 32'd3);
`else
      check("narrow_wrap", {30'd0, match_count_n}, 32'd1);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         logic               r_rst, r_we, r_ovl, r_iv, r_b;
         logic [MAX_LEN-1:0] r_pat;
         logic [LEN_W-1:0]   r_len;
         r_rst = ($urandom_range(0, 299) == 0);
         r_we  = ($urandom_range(0, 29) == 0);
         r_pat = MAX_LEN'($urandom);
         r_ovl = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       r_len = 4'd0;
            1:       r_len = 4'($urandom_range(MAX_LEN + 1, 15));
            2, 3:    r_len = 4'($urandom_range(1, MAX_LEN));
            default: r_len = 4'($urandom_range(1, 4));
         endcase
         r_iv = ($urandom_range(0, 3) != 0);
         r_b  = 1'($urandom_range(0, 1));
         step(r_rst, r_we, r_pat, r_len, r_ovl, r_iv, r_b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
